// File: rtl/scene_cmd_scheduler.sv
// scene_cmd_scheduler
//   Receives a scene from the host as 64-bit command words and writes it into
//   the shadow bank of a double-buffered object/camera store. The banks are
//   swapped at the next renderer frame boundary once the scene has been committed.
//
// Ports
//   clk, rst         system clock, asynchronous active-high reset
//   recv_dv          one-cycle strobe, recv_64bit valid
//   recv_64bit       [63:60] opcode, [59:56] index, [55:0] payload
//   frame_done       one-cycle end-of-frame strobe from the renderer
//   obj_we/addr/data registered object-RAM write, addr = {bank, index}
//   cam_we/bank/data registered camera write
//   active_bank      bank the renderer currently reads
//   obj_count        object count of the active scene
//   frame_start      one-cycle strobe on bank swap
//   recv_interrupt   high when ready for a new scene
//   err              sticky protocol error, cleared by an accepted BEGIN in IDLE

module scene_cmd_scheduler #(
    parameter int unsigned MAX_OBJ     = 16,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        recv_dv,
    input  logic [63:0] recv_64bit,
    input  logic        frame_done,
    output logic        obj_we,
    output logic [4:0]  obj_addr,
    output logic [55:0] obj_data,
    output logic        cam_we,
    output logic        cam_bank,
    output logic [55:0] cam_data,
    output logic        active_bank,
    output logic [4:0]  obj_count,
    output logic        frame_start,
    output logic        recv_interrupt,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StLoad, StPending} state_e;

    localparam logic [3:0]  OpBegin    = 4'h1;
    localparam logic [3:0]  OpObj      = 4'h2;
    localparam logic [3:0]  OpCam      = 4'h3;
    localparam logic [3:0]  OpCommit   = 4'hF;
    localparam logic [19:0] TimeoutVal = 20'(TIMEOUT_CYC);
    localparam logic [4:0]  MaxObj     = 5'(MAX_OBJ);

    state_e      state_q, state_d;
    logic        active_bank_q, active_bank_d;
    logic [4:0]  obj_count_q, obj_count_d;
    logic [4:0]  n_q, n_d;
    logic [15:0] mask_q, mask_d;
    logic [19:0] wdog_q, wdog_d;
    logic        err_q, err_d;
    logic        obj_we_q, obj_we_d;
    logic [4:0]  obj_addr_q, obj_addr_d;
    logic [55:0] obj_data_q, obj_data_d;
    logic        cam_we_q, cam_we_d;
    logic        cam_bank_q, cam_bank_d;
    logic [55:0] cam_data_q, cam_data_d;
    logic        frame_start_q, frame_start_d;
    logic        recv_int_q, recv_int_d;

    logic [3:0]  opcode;
    logic [3:0]  index;
    logic [55:0] payload;
    logic [4:0]  begin_n;
    logic        begin_ok;
    logic [16:0] need_mask;
    logic        mask_ok;

    assign opcode   = recv_64bit[63:60];
    assign index    = recv_64bit[59:56];
    assign payload  = recv_64bit[55:0];
    assign begin_n  = payload[4:0];
    assign begin_ok = (begin_n != 5'd0) && (begin_n <= MaxObj);

    // Slots 0..N-1 must all have been written before a commit is accepted.
    assign need_mask = (17'd1 << n_q) - 17'd1;
    assign mask_ok   = (mask_q & need_mask[15:0]) == need_mask[15:0];

    always_comb begin
        state_d       = state_q;
        active_bank_d = active_bank_q;
        obj_count_d   = obj_count_q;
        n_d           = n_q;
        mask_d        = mask_q;
        wdog_d        = wdog_q;
        err_d         = err_q;
        obj_we_d      = 1'b0;
        obj_addr_d    = obj_addr_q;
        obj_data_d    = obj_data_q;
        cam_we_d      = 1'b0;
        cam_bank_d    = cam_bank_q;
        cam_data_d    = cam_data_q;
        frame_start_d = 1'b0;

        case (state_q)
            StIdle: begin
                wdog_d = 20'd0;
                if (recv_dv) begin
                    if (opcode == OpBegin && begin_ok) begin
                        state_d = StLoad;
                        n_d     = begin_n;
                        mask_d  = 16'd0;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StLoad: begin
                if (recv_dv) begin
                    wdog_d = 20'd0;
                    case (opcode)
                        OpBegin: begin
                            if (begin_ok) begin
                                n_d    = begin_n;
                                mask_d = 16'd0;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OpObj: begin
                            if ({1'b0, index} < n_q) begin
                                obj_we_d      = 1'b1;
                                obj_addr_d    = {~active_bank_q, index};
                                obj_data_d    = payload;
                                mask_d[index] = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OpCam: begin
                            cam_we_d   = 1'b1;
                            cam_bank_d = ~active_bank_q;
                            cam_data_d = payload;
                        end
                        OpCommit: begin
                            if (mask_ok) begin
                                state_d = StPending;
                            end else begin
                                state_d = StIdle;
                                err_d   = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end else if (wdog_q + 20'd1 == TimeoutVal) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    wdog_d  = 20'd0;
                end else begin
                    wdog_d = wdog_q + 20'd1;
                end
            end

            StPending: begin
                wdog_d = 20'd0;
                // Host words are never accepted here, even in the swap cycle.
                if (recv_dv) begin
                    err_d = 1'b1;
                end
                if (frame_done) begin
                    active_bank_d = ~active_bank_q;
                    obj_count_d   = n_q;
                    frame_start_d = 1'b1;
                    state_d       = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase

        recv_int_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            active_bank_q <= 1'b0;
            obj_count_q   <= 5'd0;
            n_q           <= 5'd0;
            mask_q        <= 16'd0;
            wdog_q        <= 20'd0;
            err_q         <= 1'b0;
            obj_we_q      <= 1'b0;
            obj_addr_q    <= 5'd0;
            obj_data_q    <= 56'd0;
            cam_we_q      <= 1'b0;
            cam_bank_q    <= 1'b0;
            cam_data_q    <= 56'd0;
            frame_start_q <= 1'b0;
            recv_int_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_bank_q <= active_bank_d;
            obj_count_q   <= obj_count_d;
            n_q           <= n_d;
            mask_q        <= mask_d;
            wdog_q        <= wdog_d;
            err_q         <= err_d;
            obj_we_q      <= obj_we_d;
            obj_addr_q    <= obj_addr_d;
            obj_data_q    <= obj_data_d;
            cam_we_q      <= cam_we_d;
            cam_bank_q    <= cam_bank_d;
            cam_data_q    <= cam_data_d;
            frame_start_q <= frame_start_d;
            recv_int_q    <= recv_int_d;
        end
    end

    assign obj_we         = obj_we_q;
    assign obj_addr       = obj_addr_q;
    assign obj_data       = obj_data_q;
    assign cam_we         = cam_we_q;
    assign cam_bank       = cam_bank_q;
    assign cam_data       = cam_data_q;
    assign active_bank    = active_bank_q;
    assign obj_count      = obj_count_q;
    assign frame_start    = frame_start_q;
    assign recv_interrupt = recv_int_q;
    assign err            = err_q;

endmodule

// File: tb/tb_scene_cmd_scheduler.sv
// Bench for scene_cmd_scheduler: directed command sequences; expected writes and
// bank swaps go into queues that a negedge monitor pops whenever a strobe fires.

module tb_scene_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        recv_dv;
    logic [63:0] recv_64bit;
    logic        frame_done;
    logic        obj_we;
    logic [4:0]  obj_addr;
    logic [55:0] obj_data;
    logic        cam_we;
    logic        cam_bank;
    logic [55:0] cam_data;
    logic        active_bank;
    logic [4:0]  obj_count;
    logic        frame_start;
    logic        recv_interrupt;
    logic        err;

    always #5 clk = ~clk;

    scene_cmd_scheduler #(
        .MAX_OBJ    (16),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .recv_dv       (recv_dv),
        .recv_64bit    (recv_64bit),
        .frame_done    (frame_done),
        .obj_we        (obj_we),
        .obj_addr      (obj_addr),
        .obj_data      (obj_data),
        .cam_we        (cam_we),
        .cam_bank      (cam_bank),
        .cam_data      (cam_data),
        .active_bank   (active_bank),
        .obj_count     (obj_count),
        .frame_start   (frame_start),
        .recv_interrupt(recv_interrupt),
        .err           (err)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [55:0] data;
    } obj_t;
    typedef struct {
        logic        bank;
        logic [55:0] data;
    } cam_t;
    typedef struct {
        logic       bank;
        logic [4:0] count;
    } frm_t;

    obj_t obj_q[$];
    cam_t cam_q[$];
    frm_t frm_q[$];
    obj_t e_obj;
    cam_t e_cam;
    frm_t e_frm;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [3:0] idx,
                                       input logic [55:0] pl);
        return {op, idx, pl};
    endfunction

    task automatic send(input logic [63:0] w);
        @(negedge clk);
        recv_dv    = 1'b1;
        recv_64bit = w;
        @(negedge clk);
        recv_dv    = 1'b0;
    endtask

    task automatic exp_obj(input logic [4:0] a, input logic [55:0] d);
        obj_t t;
        t.addr = a;
        t.data = d;
        obj_q.push_back(t);
    endtask

    task automatic exp_cam(input logic b, input logic [55:0] d);
        cam_t t;
        t.bank = b;
        t.data = d;
        cam_q.push_back(t);
    endtask

    task automatic exp_frm(input logic b, input logic [4:0] c);
        frm_t t;
        t.bank  = b;
        t.count = c;
        frm_q.push_back(t);
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_obj_we"}, {63'd0, obj_we}, 64'd0);
        chk({tag, "_obj_addr"}, {59'd0, obj_addr}, 64'd0);
        chk({tag, "_obj_data"}, {8'd0, obj_data}, 64'd0);
        chk({tag, "_cam_we"}, {63'd0, cam_we}, 64'd0);
        chk({tag, "_cam_bank"}, {63'd0, cam_bank}, 64'd0);
        chk({tag, "_cam_data"}, {8'd0, cam_data}, 64'd0);
        chk({tag, "_active_bank"}, {63'd0, active_bank}, 64'd0);
        chk({tag, "_obj_count"}, {59'd0, obj_count}, 64'd0);
        chk({tag, "_frame_start"}, {63'd0, frame_start}, 64'd0);
        chk({tag, "_recv_int"}, {63'd0, recv_interrupt}, 64'd0);
        chk({tag, "_err"}, {63'd0, err}, 64'd0);
    endtask

    // Monitor: every strobe must match the oldest expectation; an unexpected
    // strobe (or one held for a second cycle) finds an empty queue.
    always @(negedge clk) begin
        if (obj_we) begin
            if (obj_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL obj_we_unexpected: got addr 0x%0h, required no write", obj_addr);
            end else begin
                e_obj = obj_q.pop_front();
                chk("obj_addr", {59'd0, obj_addr}, {59'd0, e_obj.addr});
                chk("obj_data", {8'd0, obj_data}, {8'd0, e_obj.data});
            end
        end
        if (cam_we) begin
            if (cam_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cam_we_unexpected: got bank %0d, required no write", cam_bank);
            end else begin
                e_cam = cam_q.pop_front();
                chk("cam_bank", {63'd0, cam_bank}, {63'd0, e_cam.bank});
                chk("cam_data", {8'd0, cam_data}, {8'd0, e_cam.data});
            end
        end
        if (frame_start) begin
            if (frm_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_start_unexpected: got 1, required 0 at %0t", $time);
            end else begin
                e_frm = frm_q.pop_front();
                chk("swap_active_bank", {63'd0, active_bank}, {63'd0, e_frm.bank});
                chk("swap_obj_count", {59'd0, obj_count}, {59'd0, e_frm.count});
                chk("swap_recv_int", {63'd0, recv_interrupt}, 64'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        recv_dv    = 1'b0;
        recv_64bit = 64'd0;
        frame_done = 1'b0;
        #23;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ri_after_rst", {63'd0, recv_interrupt}, 64'd1);

        // Normal scene into bank 1
        send(mk(4'h1, 4'h0, 56'd2));
        chk("load_ri_low", {63'd0, recv_interrupt}, 64'd0);
        exp_obj(5'h10, 56'hA0);
        send(mk(4'h2, 4'h0, 56'hA0));
        exp_obj(5'h11, 56'hA1);
        send(mk(4'h2, 4'h1, 56'hA1));
        exp_cam(1'b1, 56'hCC);
        send(mk(4'h3, 4'h0, 56'hCC));
        send(mk(4'hF, 4'h0, 56'd0));
        chk("pending_ri_low", {63'd0, recv_interrupt}, 64'd0);
        chk("pending_err", {63'd0, err}, 64'd0);
        exp_frm(1'b1, 5'd2);
        pulse_frame();
        chk("s1_active_bank", {63'd0, active_bank}, 64'd1);
        chk("s1_obj_count", {59'd0, obj_count}, 64'd2);

        // frame_done outside PENDING does nothing
        pulse_frame();
        chk("idle_frame_bank", {63'd0, active_bank}, 64'd1);

        // Incomplete commit; writes target bank 0 now
        send(mk(4'h1, 4'h0, 56'd3));
        exp_obj(5'h00, 56'hB0);
        send(mk(4'h2, 4'h0, 56'hB0));
        exp_obj(5'h02, 56'hB2);
        send(mk(4'h2, 4'h2, 56'hB2));
        exp_cam(1'b0, 56'hC1);
        send(mk(4'h3, 4'h0, 56'hC1));
        send(mk(4'hF, 4'h0, 56'd0));
        chk("incomplete_err", {63'd0, err}, 64'd1);
        chk("incomplete_ri", {63'd0, recv_interrupt}, 64'd1);
        pulse_frame();
        chk("incomplete_bank", {63'd0, active_bank}, 64'd1);

        // Out-of-range OBJ index, then recover and commit
        send(mk(4'h1, 4'h0, 56'd2));
        chk("begin_clears_err", {63'd0, err}, 64'd0);
        send(mk(4'h2, 4'h5, 56'hDD));
        chk("bad_idx_err", {63'd0, err}, 64'd1);
        chk("bad_idx_still_load", {63'd0, recv_interrupt}, 64'd0);
        exp_obj(5'h00, 56'hE0);
        send(mk(4'h2, 4'h0, 56'hE0));
        exp_obj(5'h01, 56'hE1);
        send(mk(4'h2, 4'h1, 56'hE1));
        send(mk(4'hF, 4'h0, 56'd0));
        chk("bad_idx_pending", {63'd0, recv_interrupt}, 64'd0);
        exp_frm(1'b0, 5'd2);
        pulse_frame();
        chk("s3_active_bank", {63'd0, active_bank}, 64'd0);

        // OBJ arriving in the swap cycle is dropped
        send(mk(4'h1, 4'h0, 56'd1));
        exp_obj(5'h10, 56'hF0);
        send(mk(4'h2, 4'h0, 56'hF0));
        send(mk(4'hF, 4'h0, 56'd0));
        chk("s4_err_clean", {63'd0, err}, 64'd0);
        exp_frm(1'b1, 5'd1);
        @(negedge clk);
        frame_done = 1'b1;
        recv_dv    = 1'b1;
        recv_64bit = mk(4'h2, 4'h0, 56'h99);
        @(negedge clk);
        frame_done = 1'b0;
        recv_dv    = 1'b0;
        chk("swap_drop_err", {63'd0, err}, 64'd1);
        chk("swap_drop_bank", {63'd0, active_bank}, 64'd1);

        // Watchdog: 8 idle cycles in LOAD abort
        send(mk(4'h1, 4'h0, 56'd1));
        chk("wd_err_clear", {63'd0, err}, 64'd0);
        repeat (7) @(negedge clk);
        chk("wd_ri_before", {63'd0, recv_interrupt}, 64'd0);
        chk("wd_err_before", {63'd0, err}, 64'd0);
        @(negedge clk);
        chk("wd_ri_after", {63'd0, recv_interrupt}, 64'd1);
        chk("wd_err_after", {63'd0, err}, 64'd1);

        // Reset mid-LOAD, then a fresh scene into bank 1
        send(mk(4'h1, 4'h0, 56'd2));
        exp_obj(5'h00, 56'h11);
        send(mk(4'h2, 4'h0, 56'h11));
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midload_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ri_after_rst2", {63'd0, recv_interrupt}, 64'd1);
        send(mk(4'h1, 4'h0, 56'd1));
        exp_obj(5'h10, 56'h22);
        send(mk(4'h2, 4'h0, 56'h22));
        exp_cam(1'b1, 56'h33);
        send(mk(4'h3, 4'h0, 56'h33));
        send(mk(4'hF, 4'h0, 56'd0));
        exp_frm(1'b1, 5'd1);
        pulse_frame();
        chk("s6_active_bank", {63'd0, active_bank}, 64'd1);
        chk("s6_err", {63'd0, err}, 64'd0);

        // Unknown opcode in IDLE
        send(mk(4'h5, 4'h0, 56'd0));
        chk("bad_op_err", {63'd0, err}, 64'd1);

        repeat (3) @(negedge clk);
        chk("obj_q_drained", 64'(obj_q.size()), 64'd0);
        chk("cam_q_drained", 64'(cam_q.size()), 64'd0);
        chk("frm_q_drained", 64'(frm_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
